// File: rtl/egress_top.sv
`default_nettype none
// ============================================================================
//  Module   : egress_top
//  Purpose  : PCIe egress merge. Packets arriving from the send (sd), receive
//             (rc) and register (rg) action modules on the internal sop/eop
//             stream are merged, one whole packet at a time, onto the Xilinx
//             PCIe IP core TX AXI4-Stream port.
//             - Packet-level round-robin arbitration. After reset the
//               priority order is sd > rc > rg, and the most recent winner
//               drops to lowest priority.
//             - Internal-to-Xilinx sideband mapping: tlast = eop, and
//               tuser[1] (err_fwd) = internal tuser[0].
//             - A 2-entry skid buffer drives the output, and every
//               m_axis_tx_* signal comes straight from a register.
//             - Stray beats (tvalid without sop while idle) are accepted,
//               discarded and counted in a saturating 16-bit counter.
//  Ports    : clk, rst_n                    clock, async active-low reset
//             {sd,rc,rg}_s_axis_*           tvalid/tready/sop/eop/tdata/
//                                           tkeep/tuser input streams
//             m_axis_tx_*                   tvalid/tready/tlast/tdata/tkeep/
//                                           tuser output to the IP core
//             drop_cnt                      discarded stray beat count
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef PCIE_DATA_WIDTH
`define PCIE_DATA_WIDTH 64
`endif
`ifndef PCIE_DATA_KW
`define PCIE_DATA_KW 8
`endif
`ifndef PCIE_TUSER_W
`define PCIE_TUSER_W 4
`endif
`ifndef XIL_TX_USER_W
`define XIL_TX_USER_W 4
`endif

module egress_top #(
    parameter int DATA_W  = `PCIE_DATA_WIDTH,
    parameter int KEEP_W  = `PCIE_DATA_KW,
    parameter int IUSER_W = `PCIE_TUSER_W,
    parameter int XUSER_W = `XIL_TX_USER_W
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               sd_s_axis_tvalid,
    output logic               sd_s_axis_tready,
    input  logic               sd_s_axis_sop,
    input  logic               sd_s_axis_eop,
    input  logic [DATA_W-1:0]  sd_s_axis_tdata,
    input  logic [KEEP_W-1:0]  sd_s_axis_tkeep,
    input  logic [IUSER_W-1:0] sd_s_axis_tuser,

    input  logic               rc_s_axis_tvalid,
    output logic               rc_s_axis_tready,
    input  logic               rc_s_axis_sop,
    input  logic               rc_s_axis_eop,
    input  logic [DATA_W-1:0]  rc_s_axis_tdata,
    input  logic [KEEP_W-1:0]  rc_s_axis_tkeep,
    input  logic [IUSER_W-1:0] rc_s_axis_tuser,

    input  logic               rg_s_axis_tvalid,
    output logic               rg_s_axis_tready,
    input  logic               rg_s_axis_sop,
    input  logic               rg_s_axis_eop,
    input  logic [DATA_W-1:0]  rg_s_axis_tdata,
    input  logic [KEEP_W-1:0]  rg_s_axis_tkeep,
    input  logic [IUSER_W-1:0] rg_s_axis_tuser,

    input  logic               m_axis_tx_tready,
    output logic               m_axis_tx_tvalid,
    output logic               m_axis_tx_tlast,
    output logic [DATA_W-1:0]  m_axis_tx_tdata,
    output logic [KEEP_W-1:0]  m_axis_tx_tkeep,
    output logic [XUSER_W-1:0] m_axis_tx_tuser,

    output logic [15:0]        drop_cnt
);

    localparam logic [1:0] c_SRC_SD = 2'd0;
    localparam logic [1:0] c_SRC_RC = 2'd1;
    localparam logic [1:0] c_SRC_RG = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic [1:0] r_grant, w_grant_nxt;
    logic [1:0] r_rr_ptr, w_rr_ptr_nxt;   // index of the highest-priority source
    logic       r_run;                    // low during reset and the first cycle after it

    // Gather the three inputs into indexable form.
    logic [2:0] w_vld, w_sop, w_eop;
    logic [2:0] w_req, w_rdy, w_drop;

    assign w_vld = {rg_s_axis_tvalid, rc_s_axis_tvalid, sd_s_axis_tvalid};
    assign w_sop = {rg_s_axis_sop,    rc_s_axis_sop,    sd_s_axis_sop};
    assign w_eop = {rg_s_axis_eop,    rc_s_axis_eop,    sd_s_axis_eop};
    assign w_req = w_vld & w_sop;

    // Selected (granted) source payload.
    logic               w_sel_vld, w_sel_eop;
    logic [DATA_W-1:0]  w_sel_dat;
    logic [KEEP_W-1:0]  w_sel_keep;
    logic [IUSER_W-1:0] w_sel_user;

    always_comb begin
        w_sel_vld  = 1'b0;
        w_sel_eop  = 1'b0;
        w_sel_dat  = '0;
        w_sel_keep = '0;
        w_sel_user = '0;
        case (r_grant)
            c_SRC_SD: begin
                w_sel_vld  = sd_s_axis_tvalid;
                w_sel_eop  = sd_s_axis_eop;
                w_sel_dat  = sd_s_axis_tdata;
                w_sel_keep = sd_s_axis_tkeep;
                w_sel_user = sd_s_axis_tuser;
            end
            c_SRC_RC: begin
                w_sel_vld  = rc_s_axis_tvalid;
                w_sel_eop  = rc_s_axis_eop;
                w_sel_dat  = rc_s_axis_tdata;
                w_sel_keep = rc_s_axis_tkeep;
                w_sel_user = rc_s_axis_tuser;
            end
            c_SRC_RG: begin
                w_sel_vld  = rg_s_axis_tvalid;
                w_sel_eop  = rg_s_axis_eop;
                w_sel_dat  = rg_s_axis_tdata;
                w_sel_keep = rg_s_axis_tkeep;
                w_sel_user = rg_s_axis_tuser;
            end
            default: ;
        endcase
    end

    // Only internal tuser[0] has a meaning on the Xilinx side.
    logic               w_unused_user;
    logic [XUSER_W-1:0] w_map_user;

    assign w_unused_user = |w_sel_user;

    always_comb begin
        w_map_user    = '0;
        w_map_user[1] = w_sel_user[0];
    end

    // Skid buffer storage.
    logic               r_out_vld, r_out_last;
    logic [DATA_W-1:0]  r_out_dat;
    logic [KEEP_W-1:0]  r_out_keep;
    logic [XUSER_W-1:0] r_out_user;
    logic               r_skid_vld, r_skid_last;
    logic [DATA_W-1:0]  r_skid_dat;
    logic [KEEP_W-1:0]  r_skid_keep;
    logic [XUSER_W-1:0] r_skid_user;

    logic w_in_ready, w_push, w_out_load;

    // The buffer refuses new beats only when both entries are occupied.
    assign w_in_ready = ~r_skid_vld;
    assign w_push     = r_run && (r_state == ST_XFER) && w_sel_vld && w_in_ready;
    assign w_out_load = ~r_out_vld | m_axis_tx_tready;

    // Round-robin search starting at the current highest-priority source.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic       found;
        int         s;
        logic [1:0] idx;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s = int'(ptr) + k;
            if (s >= 3) begin
                s = s - 3;
            end
            idx = s[1:0];
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    logic [1:0] w_pick;
    assign w_pick = rr_pick(w_req, r_rr_ptr);

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        w_rdy        = 3'b000;
        w_drop       = 3'b000;
        if (r_run) begin
            case (r_state)
                ST_IDLE: begin
                    // Beats without sop outside a packet are swallowed here;
                    // sop beats wait for the grant to take effect in XFER.
                    w_drop = w_vld & ~w_sop;
                    w_rdy  = w_drop;
                    if (|w_req) begin
                        w_state_nxt  = ST_XFER;
                        w_grant_nxt  = w_pick;
                        w_rr_ptr_nxt = (w_pick == c_SRC_RG) ? c_SRC_SD : w_pick + 2'd1;
                    end
                end
                ST_XFER: begin
                    w_rdy = w_in_ready ? (3'b001 << r_grant) : 3'b000;
                    // A stray sop mid-packet is just data; only eop closes the packet.
                    if (w_push && w_sel_eop) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign sd_s_axis_tready = w_rdy[0];
    assign rc_s_axis_tready = w_rdy[1];
    assign rg_s_axis_tready = w_rdy[2];

    // Saturating drop counter; several sources may drop in the same cycle.
    logic [1:0]  w_drop_sum;
    logic [16:0] w_drop_tot;
    logic [15:0] r_drop_cnt, w_drop_nxt;

    assign w_drop_sum = 2'(w_drop[0]) + 2'(w_drop[1]) + 2'(w_drop[2]);
    assign w_drop_tot = {1'b0, r_drop_cnt} + {15'd0, w_drop_sum};
    assign w_drop_nxt = w_drop_tot[16] ? 16'hFFFF : w_drop_tot[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= c_SRC_SD;
            r_rr_ptr   <= c_SRC_SD;
            r_run      <= 1'b0;
            r_drop_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_run      <= 1'b1;
            r_drop_cnt <= w_drop_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld   <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_dat   <= '0;
            r_out_keep  <= '0;
            r_out_user  <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_last <= 1'b0;
            r_skid_dat  <= '0;
            r_skid_keep <= '0;
            r_skid_user <= '0;
        end else if (w_out_load) begin
            // Output register is free (or being consumed): the older skid
            // entry goes first, otherwise take the incoming beat directly.
            if (r_skid_vld) begin
                r_out_vld  <= 1'b1;
                r_out_last <= r_skid_last;
                r_out_dat  <= r_skid_dat;
                r_out_keep <= r_skid_keep;
                r_out_user <= r_skid_user;
                r_skid_vld <= 1'b0;
            end else if (w_push) begin
                r_out_vld  <= 1'b1;
                r_out_last <= w_sel_eop;
                r_out_dat  <= w_sel_dat;
                r_out_keep <= w_sel_keep;
                r_out_user <= w_map_user;
            end else begin
                r_out_vld  <= 1'b0;
            end
        end else if (w_push) begin
            // Output stalled and held: park the new beat in the skid entry.
            r_skid_vld  <= 1'b1;
            r_skid_last <= w_sel_eop;
            r_skid_dat  <= w_sel_dat;
            r_skid_keep <= w_sel_keep;
            r_skid_user <= w_map_user;
        end
    end

    assign m_axis_tx_tvalid = r_out_vld;
    assign m_axis_tx_tlast  = r_out_last;
    assign m_axis_tx_tdata  = r_out_dat;
    assign m_axis_tx_tkeep  = r_out_keep;
    assign m_axis_tx_tuser  = r_out_user;
    assign drop_cnt         = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_egress_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_egress_top
//  Purpose  : Self-checking bench for egress_top. Expected output beats are
//             queued in predicted order as stimulus is prepared and compared
//             as the DUT hands beats to the (modelled) IP core.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_egress_top;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int UW = 4;
    localparam int XW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]    s_vld, s_sop, s_eop, s_rdy;
    logic [DW-1:0] s_dat  [3];
    logic [KW-1:0] s_keep [3];
    logic [UW-1:0] s_user [3];

    logic          m_tready;
    logic          m_tvalid, m_tlast;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [XW-1:0] m_tuser;
    logic [15:0]   drop_cnt;

    egress_top #(
        .DATA_W (DW),
        .KEEP_W (KW),
        .IUSER_W(UW),
        .XUSER_W(XW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sd_s_axis_tvalid(s_vld[0]),
        .sd_s_axis_tready(s_rdy[0]),
        .sd_s_axis_sop   (s_sop[0]),
        .sd_s_axis_eop   (s_eop[0]),
        .sd_s_axis_tdata (s_dat[0]),
        .sd_s_axis_tkeep (s_keep[0]),
        .sd_s_axis_tuser (s_user[0]),
        .rc_s_axis_tvalid(s_vld[1]),
        .rc_s_axis_tready(s_rdy[1]),
        .rc_s_axis_sop   (s_sop[1]),
        .rc_s_axis_eop   (s_eop[1]),
        .rc_s_axis_tdata (s_dat[1]),
        .rc_s_axis_tkeep (s_keep[1]),
        .rc_s_axis_tuser (s_user[1]),
        .rg_s_axis_tvalid(s_vld[2]),
        .rg_s_axis_tready(s_rdy[2]),
        .rg_s_axis_sop   (s_sop[2]),
        .rg_s_axis_eop   (s_eop[2]),
        .rg_s_axis_tdata (s_dat[2]),
        .rg_s_axis_tkeep (s_keep[2]),
        .rg_s_axis_tuser (s_user[2]),
        .m_axis_tx_tready(m_tready),
        .m_axis_tx_tvalid(m_tvalid),
        .m_axis_tx_tlast (m_tlast),
        .m_axis_tx_tdata (m_tdata),
        .m_axis_tx_tkeep (m_tkeep),
        .m_axis_tx_tuser (m_tuser),
        .drop_cnt        (drop_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [XW-1:0] u;
        logic          l;
    } beat_t;

    beat_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int t0       = 0;
    int first_tv_cyc = -1;
    logic tv_arm = 1'b0;
    logic bp_en  = 1'b0;
    logic hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (bp_en) m_tready = ~m_tready;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] mkdata(input int src, input int pkt, input int b);
        return {8'hA5, 8'(src), 8'(pkt), 32'h0, 8'(b)};
    endfunction

    function automatic logic [KW-1:0] mkkeep(input int b, input int n);
        return (b == n - 1) ? 8'h3F : 8'hFF;
    endfunction

    task automatic push_pkt(input int src, input int pkt, input int n, input logic err);
        beat_t e;
        for (int b = 0; b < n; b++) begin
            e.d = mkdata(src, pkt, b);
            e.k = mkkeep(b, n);
            e.u = {2'b00, err, 1'b0};
            e.l = (b == n - 1);
            exp_q.push_back(e);
        end
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic drive_pkt(input int src, input int pkt, input int n, input logic err, input logic stray);
        logic ok;
        for (int b = 0; b < n; b++) begin
            s_vld[src]  = 1'b1;
            s_sop[src]  = !stray && (b == 0);
            s_eop[src]  = !stray && (b == n - 1);
            s_dat[src]  = mkdata(src, pkt, b);
            s_keep[src] = mkkeep(b, n);
            s_user[src] = {3'b101, err};
            ok = 1'b0;
            for (int c = 0; c < 300 && !ok; c++) begin
                #4;
                ok = s_rdy[src];
                @(negedge clk);
            end
            if (!ok) check_eq("handshake_timeout", 0, 1);
        end
        s_vld[src] = 1'b0;
        s_sop[src] = 1'b0;
        s_eop[src] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(negedge clk);
        check_eq("queue_drained", 64'(exp_q.size()), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Output monitor / scoreboard, sampling just before each rising edge.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                hold_v = 1'b0;
            end else begin
                if (tv_arm && m_tvalid) begin
                    first_tv_cyc = cyc;
                    tv_arm = 1'b0;
                end
                if (hold_v) begin
                    check_eq("hold_tvalid", m_tvalid, 1);
                    check_eq("hold_tdata", m_tdata, hold_d);
                end
                hold_v = m_tvalid && !m_tready;
                hold_d = m_tdata;
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_beat", m_tdata, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("tdata", m_tdata, e.d);
                        check_eq("tkeep", m_tkeep, e.k);
                        check_eq("tuser", m_tuser, e.u);
                        check_eq("tlast", m_tlast, e.l);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        beat_t e;
        s_vld = '0; s_sop = '0; s_eop = '0;
        for (int i = 0; i < 3; i++) begin
            s_dat[i] = '0; s_keep[i] = '0; s_user[i] = '0;
        end
        m_tready = 1'b1;

        // Reset values, with a stray beat offered on rg during reset.
        s_vld[2] = 1'b1;
        #12;
        check_eq("rst_tvalid", m_tvalid, 0);
        check_eq("rst_tlast", m_tlast, 0);
        check_eq("rst_tdata", m_tdata, 0);
        check_eq("rst_tkeep", m_tkeep, 0);
        check_eq("rst_tuser", m_tuser, 0);
        check_eq("rst_drop_cnt", drop_cnt, 0);
        check_eq("rst_tready", s_rdy, 0);
        s_vld[2] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single 4-beat sd packet, first tvalid two cycles after sd tvalid.
        push_pkt(0, 1, 4, 1'b0);
        tv_arm = 1'b1;
        t0 = cyc;
        drive_pkt(0, 1, 4, 1'b0, 1'b0);
        wait_drain();
        check_eq("first_tvalid_latency", 64'(first_tv_cyc - t0), 2);

        // Contention: all three sources, two 2-beat packets each.
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 3; s++) push_pkt(s, 10 + p, 2, 1'b0);
        fork
            begin drive_pkt(0, 10, 2, 1'b0, 1'b0); drive_pkt(0, 11, 2, 1'b0, 1'b0); end
            begin drive_pkt(1, 10, 2, 1'b0, 1'b0); drive_pkt(1, 11, 2, 1'b0, 1'b0); end
            begin drive_pkt(2, 10, 2, 1'b0, 1'b0); drive_pkt(2, 11, 2, 1'b0, 1'b0); end
        join
        wait_drain();

        // Backpressure: IP core ready toggling during an 8-beat rc packet.
        push_pkt(1, 20, 8, 1'b0);
        bp_en = 1'b1;
        drive_pkt(1, 20, 8, 1'b0, 1'b0);
        wait_drain();
        bp_en = 1'b0;
        m_tready = 1'b1;
        repeat (2) @(negedge clk);

        // Stray beats on rg while idle.
        do_reset();
        drive_pkt(2, 0, 3, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check_eq("drop_cnt_3", drop_cnt, 3);
        check_eq("stray_no_output", m_tvalid, 0);

        // Saturation: three sources dropping every cycle.
        do_reset();
        s_vld = 3'b111;
        repeat (21844) @(negedge clk);
        s_vld = 3'b000;
        check_eq("drop_cnt_multi", drop_cnt, 65532);
        s_vld = 3'b111;
        @(negedge clk);
        s_vld = 3'b000;
        check_eq("drop_cnt_reach_max", drop_cnt, 16'hFFFF);
        s_vld[2] = 1'b1;
        @(negedge clk);
        s_vld = 3'b000;
        check_eq("drop_cnt_sat_one", drop_cnt, 16'hFFFF);
        s_vld = 3'b111;
        @(negedge clk);
        s_vld = 3'b000;
        check_eq("drop_cnt_sat_three", drop_cnt, 16'hFFFF);
        @(negedge clk);

        // Sideband: single-beat sd packet with error-forward request.
        push_pkt(0, 30, 1, 1'b1);
        drive_pkt(0, 30, 1, 1'b1, 1'b0);
        wait_drain();

        // Reset in the middle of a 5-beat sd packet.
        e.d = mkdata(0, 40, 0); e.k = 8'hFF; e.u = '0; e.l = 1'b0;
        exp_q.push_back(e);
        s_vld[0] = 1'b1; s_sop[0] = 1'b1; s_eop[0] = 1'b0;
        s_dat[0] = mkdata(0, 40, 0); s_keep[0] = 8'hFF; s_user[0] = '0;
        @(negedge clk);
        @(negedge clk);
        s_sop[0] = 1'b0;
        s_dat[0] = mkdata(0, 40, 1);
        @(negedge clk);
        s_dat[0] = mkdata(0, 40, 2);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midpkt_rst_tvalid", m_tvalid, 0);
        check_eq("midpkt_rst_tready", s_rdy, 0);
        check_eq("midpkt_beats_left", 64'(exp_q.size()), 0);
        s_vld = 3'b000;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_pkt(1, 50, 2, 1'b0);
        push_pkt(2, 51, 2, 1'b0);
        fork
            drive_pkt(1, 50, 2, 1'b0, 1'b0);
            drive_pkt(2, 51, 2, 1'b0, 1'b0);
        join
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
